// File: rtl/sa_row_seq_ctrl_if.sv
// sa_row_seq_ctrl_if: job control, buffer strobes and tagged-result signals
// between a systolic-row sequencer and its host/buffers.
interface sa_row_seq_ctrl_if #(parameter int ADDR_BW = 10);
    logic               start;
    logic               abort;
    logic [ADDR_BW-1:0] num_vec;
    logic               in_avail;
    logic               busy;
    logic               done;
    logic               w_rd_en;
    logic               we_rl;
    logic               in_rd_en;
    logic [ADDR_BW-1:0] in_rd_addr;
    logic               res_valid;
    logic [ADDR_BW-1:0] res_addr;
    modport master (
        output start, abort, num_vec, in_avail,
        input  busy, done, w_rd_en, we_rl, in_rd_en, in_rd_addr, res_valid, res_addr
    );
    modport slave (
        input  start, abort, num_vec, in_avail,
        output busy, done, w_rd_en, we_rl, in_rd_en, in_rd_addr, res_valid, res_addr
    );
endinterface

// File: rtl/sa_row_seq_ctrl.sv
// sa_row_seq_ctrl: loads weights into one weight-stationary systolic row, streams
// input vectors with bubble tolerance and tags each emerging result with its index.
module sa_row_seq_ctrl #(
    parameter int MATRIX_SIZE = 128,
    parameter int ADDR_BW     = 10,
    parameter int PIPE_LAT    = MATRIX_SIZE
) (
    input logic               clk,
    input logic               rstn,
    sa_row_seq_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_WREQ, S_WLATCH, S_FEED, S_DRAIN, S_FIN} state_t;

    state_t             r_state, w_next;
    logic [ADDR_BW-1:0] r_len, r_iss, r_recv;
    logic [PIPE_LAT:0]  r_vsr;
    logic               w_rd, w_rv;

    assign w_rd = (r_state == S_FEED) && bus.in_avail && (r_iss < r_len);
    assign w_rv = r_vsr[PIPE_LAT];

    always_ff @(posedge clk)
        r_state <= !rstn ? S_IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = (bus.start && !bus.abort) ? S_WREQ : S_IDLE;
            S_WREQ:   w_next = S_WLATCH;
            S_WLATCH: w_next = (r_len == '0) ? S_FIN : S_FEED;
            S_FEED:   w_next = (w_rd && (r_iss + ADDR_BW'(1) == r_len)) ? S_DRAIN : S_FEED;
            // last result always lands in DRAIN since PIPE_LAT >= 1
            S_DRAIN:  w_next = (w_rv && (r_recv + ADDR_BW'(1) == r_len)) ? S_FIN : S_DRAIN;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (bus.abort)
            w_next = S_IDLE;
    end

    always_comb begin
        bus.busy       = (r_state != S_IDLE);
        bus.done       = (r_state == S_FIN);
        bus.w_rd_en    = (r_state == S_WREQ);
        bus.we_rl      = (r_state == S_WLATCH);
        bus.in_rd_en   = w_rd;
        bus.in_rd_addr = r_iss;
        bus.res_valid  = w_rv;
        bus.res_addr   = r_recv;
    end

    // abort flushes in-flight valids so no stale result is ever flagged
    always_ff @(posedge clk) begin
        if (!rstn || bus.abort) begin
            r_len  <= '0;
            r_iss  <= '0;
            r_recv <= '0;
            r_vsr  <= '0;
        end else begin
            r_vsr <= {r_vsr[PIPE_LAT-1:0], w_rd};
            if (r_state == S_IDLE && bus.start) begin
                r_len  <= bus.num_vec;
                r_iss  <= '0;
                r_recv <= '0;
            end else begin
                if (w_rd)
                    r_iss <= r_iss + ADDR_BW'(1);
                if (w_rv)
                    r_recv <= r_recv + ADDR_BW'(1);
            end
        end
    end
endmodule

// File: tb/tb_sa_row_seq_ctrl.sv
// tb_sa_row_seq_ctrl: directed per-cycle checks of the row sequencer with
// MATRIX_SIZE=PIPE_LAT=4; cycle 0 of each job is the cycle start is presented.
module tb_sa_row_seq_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [5:0] exp_q[$];
    logic [5:0] flags;

    sa_row_seq_ctrl_if #(.ADDR_BW(10)) bus();

    sa_row_seq_ctrl #(.MATRIX_SIZE(4), .ADDR_BW(10), .PIPE_LAT(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign flags = {bus.busy, bus.done, bus.w_rd_en, bus.we_rl, bus.in_rd_en, bus.res_valid};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // exp_q holds {busy,done,w_rd_en,we_rl,in_rd_en,res_valid} per cycle;
    // expected addresses follow from counting expected reads/results.
    task automatic run(input string tag, input logic [9:0] nv, input logic [31:0] start_m,
                       input logic [31:0] abort_m, input logic [31:0] noavail_m, input logic [31:0] rst_m);
        int rd_n = 0;
        int rs_n = 0;
        for (int c = 0; c < exp_q.size(); c++) begin
            @(posedge clk);
            #1;
            bus.start    = start_m[c];
            bus.num_vec  = (c == 0) ? nv : 10'd7;
            bus.abort    = abort_m[c];
            bus.in_avail = !noavail_m[c];
            rstn         = !rst_m[c];
            #1;
            chk($sformatf("%s c%0d flags", tag, c), {26'b0, flags}, {26'b0, exp_q[c]});
            if (exp_q[c][1]) begin
                chk($sformatf("%s c%0d in_rd_addr", tag, c), {22'b0, bus.in_rd_addr}, rd_n);
                rd_n++;
            end
            if (exp_q[c][0]) begin
                chk($sformatf("%s c%0d res_addr", tag, c), {22'b0, bus.res_addr}, rs_n);
                rs_n++;
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.num_vec = '0;
        bus.in_avail = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset flags", {26'b0, flags}, 0);
        chk("reset in_rd_addr", {22'b0, bus.in_rd_addr}, 0);
        chk("reset res_addr", {22'b0, bus.res_addr}, 0);

        exp_q = '{6'b000000, 6'b101000, 6'b100100, 6'b100010, 6'b100010, 6'b100010, 6'b100000,
                  6'b100000, 6'b100001, 6'b100001, 6'b100001, 6'b110000, 6'b000000};
        run("basic3", 10'd3, 32'h1, 32'h0, 32'h0, 32'h0);

        exp_q = '{6'b000000, 6'b101000, 6'b100100, 6'b100010, 6'b100000, 6'b100010, 6'b100010,
                  6'b100000, 6'b100001, 6'b100000, 6'b100001, 6'b100001, 6'b110000, 6'b000000};
        run("bubble", 10'd3, 32'h1, 32'h0, 32'h10, 32'h0);

        exp_q = '{6'b000000, 6'b101000, 6'b100100, 6'b110000, 6'b000000, 6'b000000};
        run("zero", 10'd0, 32'h1, 32'h0, 32'h0, 32'h0);

        exp_q = '{6'b000000, 6'b000000, 6'b000000, 6'b000000};
        run("start_abort_idle", 10'd3, 32'h1, 32'h1, 32'h0, 32'h0);

        exp_q = '{6'b000000, 6'b101000, 6'b100100, 6'b100010, 6'b100010, 6'b100010, 6'b100010,
                  6'b000000};
        run("abort5", 10'd5, 32'h1, 32'h40, 32'h0, 32'h0);

        exp_q = '{6'b000000, 6'b101000, 6'b100100, 6'b100010, 6'b100010, 6'b100000, 6'b100000,
                  6'b100000, 6'b100001, 6'b100001, 6'b110000, 6'b000000};
        run("after_abort", 10'd2, 32'h1, 32'h0, 32'h0, 32'h0);

        exp_q = '{6'b000000, 6'b101000, 6'b100100, 6'b100010, 6'b100010, 6'b100010, 6'b100000,
                  6'b100000, 6'b100001, 6'b100001, 6'b100001, 6'b110000, 6'b000000, 6'b000000,
                  6'b000000};
        run("restart_ignored", 10'd3, 32'h11, 32'h0, 32'h0, 32'h0);

        exp_q = '{6'b000000, 6'b101000, 6'b100100, 6'b100010, 6'b100010, 6'b100010, 6'b100000,
                  6'b100000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
        run("reset_drain", 10'd3, 32'h1, 32'h0, 32'h0, 32'h80);

        exp_q = '{6'b000000, 6'b101000, 6'b100100, 6'b100010, 6'b100010, 6'b100010, 6'b100000,
                  6'b100000, 6'b100001, 6'b100001, 6'b100001, 6'b110000, 6'b000000};
        run("after_reset", 10'd3, 32'h1, 32'h0, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sa_row_seq_ctrl.md
Name: sa_row_seq_ctrl

Overview:
Sequencer for one weight-stationary systolic row (chain of MATRIX_SIZE PEs with a shared write-enable and a single partial-sum result).
- Fetches a weight vector from the weight buffer and latches it into the PEs.
- Streams input vectors from the input buffer, tolerating input bubbles.
- Tracks in-flight vectors through the array latency and tags each emerging result with its vector index.
- Signals completion.

Parameters:
MATRIX_SIZE, 128, PEs in the row; sets default pipeline latency.
ADDR_BW, 10, width of vector count and buffer/result addresses.
PIPE_LAT, 128, cycles from DIN presented at array to result valid at array output (must be >= 1).

Ports:
clk  input  1  clock, all logic rising-edge.
rstn  input  1  synchronous active-low reset.
start  input  1  begin a job; sampled only in IDLE.
abort  input  1  synchronous job cancel.
num_vec  input  ADDR_BW  input vectors in job; sampled with start.
in_avail  input  1  input buffer has the next vector readable this cycle.
busy  output  1  high in any state except IDLE.
done  output  1  one-cycle pulse at job completion.
w_rd_en  output  1  weight buffer read strobe; data returns next cycle.
we_rl  output  1  array weight-latch enable.
in_rd_en  output  1  input buffer read strobe; data reaches array DIN next cycle.
in_rd_addr  output  ADDR_BW  index of vector being read.
res_valid  output  1  array result is valid this cycle.
res_addr  output  ADDR_BW  vector index of current result.

Behaviour:
- Reset (rstn=0 at clk edge):
  - state=IDLE.
  - All outputs 0.
  - Counters and valid shift register cleared.
- FSM states: IDLE, WREQ, WLATCH, FEED, DRAIN, FIN.
- IDLE:
  - start=1 → capture num_vec into job_len, go to WREQ.
  - start=0 → stay.
- WREQ: w_rd_en=1 for exactly one cycle → WLATCH.
- WLATCH: we_rl=1 for exactly one cycle (weights on bus that cycle).
  - job_len=0 → FIN.
  - Otherwise → FEED.
- FEED:
  - in_rd_en = in_avail && (issued < job_len).
  - in_rd_addr = issued; issued increments on each in_rd_en.
  - When issued reaches job_len (after the final read cycle) → DRAIN.
  - in_avail=0 inserts a bubble; no read, issued holds.
- DRAIN: no reads. When received == job_len → FIN.
- FIN: done=1 for one cycle → IDLE. busy is 0 in the following cycle.
- Valid pipeline:
  - Shift register, depth PIPE_LAT+1, shifts every cycle; input bit = in_rd_en.
  - res_valid = last stage. Result for a read at cycle t appears at cycle t+1+PIPE_LAT.
  - Bubbles propagate as 0s; results are never reordered.
- res_addr = received counter, incremented after each res_valid cycle. First result has res_addr=0. Last has job_len-1.
- Completion: done fires only after the last result has been flagged, never earlier.
- Counters issued/received are ADDR_BW wide. job_len max 2^ADDR_BW-1; no wrap within a job. All counters reset to 0 on entry to WREQ.
- we_rl and in_rd_en are never high in the same cycle.
- w_rd_en and in_rd_en are never high in the same cycle.
- start while busy: ignored; num_vec not resampled.
- start and abort both high in IDLE: abort wins; stay IDLE.
- abort=1 in any non-IDLE state:
  - Next cycle state=IDLE, busy=0.
  - Valid pipeline and counters cleared, so results in flight are suppressed (res_valid=0).
  - No done pulse.
- Reset mid-job: same as abort plus all outputs forced 0. Job is lost.
- Abort or reset during WLATCH: we_rl has already been issued and PE weights may be stale. The next job reloads them.

Test Plan:
- MATRIX_SIZE=4, PIPE_LAT=4, start with num_vec=3, in_avail=1:
  - w_rd_en at cycle 1, we_rl at cycle 2.
  - in_rd_en at cycles 3-5 with addr 0,1,2.
  - res_valid at cycles 8-10 with res_addr 0,1,2.
  - done at cycle 11; busy=0 at cycle 12.
- Same job with in_avail=0 at cycle 4 only:
  - Reads at cycles 3,5,6 (addr 0,1,2).
  - res_valid at cycles 8,10,11; done at cycle 12.
- num_vec=0: w_rd_en at cycle 1, we_rl at cycle 2, done at cycle 3. No in_rd_en or res_valid ever.
- num_vec=5, abort asserted at cycle 6 (during FEED):
  - busy=0 from cycle 7.
  - No res_valid after cycle 6, no done.
  - Fresh start at cycle 8 runs a complete job from res_addr 0.
- start pulsed again mid-job with num_vec=7: ignored; original job (3 vectors) completes unchanged with exactly one done.
- rstn=0 for one cycle during DRAIN: all outputs 0 next cycle, state IDLE, no residual res_valid.
